// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, clear, wrap/saturate modes and zero/tc/ovf flags.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN (steps once every PRESCALE requests).
module param_updown_counter #(
  parameter int WIDTH    = 3,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic             sat,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             zero,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step_req_s;
  logic             step_fire_s;
  logic             step_up_s;
  logic [WIDTH:0]   cnt_ext_s;
  logic [WIDTH:0]   din_ext_s;
  logic [WIDTH:0]   plus_s;
  logic [WIDTH:0]   minus_s;

  assign step_req_s = inc ^ dec;
  assign step_up_s  = inc;
  assign cnt_ext_s  = {1'b0, count_q};
  assign din_ext_s  = {1'b0, data_in};
  assign plus_s     = cnt_ext_s + {{WIDTH{1'b0}}, 1'b1};
  assign minus_s    = cnt_ext_s - {{WIDTH{1'b0}}, 1'b1};

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;

  // Prescale counter: counts qualifying requests, restarts on clr/ld.
  always_comb begin
    presc_d     = presc_q;
    step_fire_s = 1'b0;
    if (clr || ld) begin
      presc_d = {PW{1'b0}};
    end else if (step_req_s) begin
      if (presc_q == PRESC_LAST) begin
        presc_d     = {PW{1'b0}};
        step_fire_s = 1'b1;
      end else begin
        presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Prescale state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= {PW{1'b0}};
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign step_fire_s = step_req_s;
`endif

  // Next count and flags, priority clr > ld > step.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = {WIDTH{1'b0}};
      ovf_d   = 1'b0;
    end else if (ld) begin
      if (din_ext_s > MAX_EXT) begin
        count_d = MAX_EXT[WIDTH-1:0];
        ovf_d   = 1'b1;
      end else begin
        count_d = data_in;
      end
    end else if (step_fire_s) begin
      if (step_up_s) begin
        if (cnt_ext_s < MAX_EXT) begin
          count_d = plus_s[WIDTH-1:0];
        end else if (sat) begin
          ovf_d = 1'b1;
        end else begin
          count_d = {WIDTH{1'b0}};
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end
      end else begin
        if (cnt_ext_s > {(WIDTH+1){1'b0}}) begin
          count_d = minus_s[WIDTH-1:0];
        end else if (sat) begin
          ovf_d = 1'b1;
        end else begin
          count_d = MAX_EXT[WIDTH-1:0];
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count and flag registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {WIDTH{1'b0}};
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out = count_q;
  assign zero     = (count_q == {WIDTH{1'b0}});
  assign tc       = tc_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed self-checking bench for param_updown_counter (WIDTH=3, MAX_VAL=5, PRESCALE=4).
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst, clr, ld, inc, dec, sat;
  logic [2:0] data_in;
  logic [2:0] data_out;
  logic       zero, tc, ovf;
  int         n_checks = 0;
  int         n_fails  = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(3), .MAX_VAL(5), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .inc(inc), .dec(dec), .sat(sat),
    .data_in(data_in), .data_out(data_out), .zero(zero), .tc(tc), .ovf(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int d, input int t, input int o);
    check({tag, " data_out"}, int'(data_out), d);
    check({tag, " tc"}, int'(tc), t);
    check({tag, " ovf"}, int'(ovf), o);
    check({tag, " zero"}, int'(zero), (d == 0) ? 1 : 0);
  endtask

  initial begin
    int exp_seq[5];
    rst = 1'b1; clr = 1'b0; ld = 1'b0; inc = 1'b1; dec = 1'b0; sat = 1'b0;
    data_in = 3'd0;
    #1;
    tick(); tick();
    check_all("reset", 0, 0, 0);

`ifndef COUNTER_PRESCALE_EN
    // Test 1: count up and wrap
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_all($sformatf("up%0d", i), i, 0, 0);
    end
    tick();
    check_all("up_wrap", 0, 1, 1);
    inc = 1'b0;
    tick();
    check_all("after_wrap", 0, 0, 1);

    // Test 2: down wrap
    clr = 1'b1; tick(); clr = 1'b0;
    check_all("clr2", 0, 0, 0);
    ld = 1'b1; data_in = 3'd3; tick(); ld = 1'b0;
    check_all("ld3", 3, 0, 0);
    dec = 1'b1;
    exp_seq = '{2, 1, 0, 5, 4};
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("dn%0d", i), exp_seq[i], (i == 3) ? 1 : 0, (i >= 3) ? 1 : 0);
    end
    // Test 2b: down saturate
    dec = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    ld = 1'b1; data_in = 3'd3; tick(); ld = 1'b0;
    check_all("ld3s", 3, 0, 0);
    sat = 1'b1; dec = 1'b1;
    exp_seq = '{2, 1, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("dns%0d", i), exp_seq[i], 0, (i >= 3) ? 1 : 0);
    end
    // Up saturate at MAX_VAL
    dec = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    ld = 1'b1; data_in = 3'd5; tick(); ld = 1'b0;
    inc = 1'b1; tick();
    check_all("ups", 5, 0, 1);
    inc = 1'b0; sat = 1'b0;

    // Test 3: over-range load then clr
    clr = 1'b1; tick(); clr = 1'b0;
    ld = 1'b1; data_in = 3'd7; tick();
    check_all("ld7", 5, 0, 1);
    data_in = 3'd1; tick();
    check_all("ld_keeps_ovf", 1, 0, 1);
    ld = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    check_all("clr3", 0, 0, 0);

    // Test 4: hold on inc&dec, ld beats step, clr beats ld
    ld = 1'b1; data_in = 3'd4; tick(); ld = 1'b0;
    inc = 1'b1; dec = 1'b1; tick();
    check_all("hold", 4, 0, 0);
    dec = 1'b0; ld = 1'b1; data_in = 3'd2; tick();
    check_all("ld_vs_inc", 2, 0, 0);
    clr = 1'b1; tick(); clr = 1'b0; ld = 1'b0; inc = 1'b0;
    check_all("clr_vs_ld", 0, 0, 0);

    // Test 5: reset mid-count
    inc = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_all("to4", 4, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_all("rst_mid", 0, 0, 0);
    tick();
    check_all("resume1", 1, 0, 0);
    tick();
    check_all("resume2", 2, 0, 0);
    inc = 1'b0;
`else
    // Test 6: prescaled counting
    rst = 1'b0; inc = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;
    inc = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("psc%0d", i), int'(data_out), i / 4);
    end
    inc = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    inc = 1'b1; tick(); tick();
    check("psc_pre_ld", int'(data_out), 0);
    inc = 1'b0; ld = 1'b1; data_in = 3'd0; tick(); ld = 1'b0;
    inc = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("psc_ld%0d", i), int'(data_out), (i == 4) ? 1 : 0);
    end
    inc = 1'b0; tick();
    check("psc_hold", int'(data_out), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
